// File: rtl/key_event_queue_ctrl.sv
// PS/2 scan-code sequencer feeding a show-ahead key event FIFO.
// Optional irq output enabled by defining KEY_EVENT_IRQ_EN.
module key_event_queue_ctrl #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  global_clk,
  input  logic                  rst_n,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  input  logic                  rd_en,
  input  logic                  clr_ovf,
  output logic [15:0]           evt_data,
  output logic                  evt_avail,
  output logic [DEPTH_LOG2:0]   evt_count,
  output logic                  overflow,
  output logic                  irq
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_PAUSE
  } state_e;

  state_e                state_q, state_d;
  logic                  ext_q, ext_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  push;
  logic [9:0]            pdat;

  logic                  is_e0, is_f0, is_e1, is_noise;

  assign is_e0    = (byte_in == 8'hE0);
  assign is_f0    = (byte_in == 8'hF0);
  assign is_e1    = (byte_in == 8'hE1);
  assign is_noise = (byte_in == 8'h00) || (byte_in == 8'hAA) ||
                    (byte_in == 8'hFA) || (byte_in == 8'hFE) ||
                    (byte_in == 8'hFF);

  // pdat packs {break, extended, code}
  always_comb begin
    state_d = state_q;
    ext_d   = ext_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    pdat    = 10'h000;
    if (byte_valid) begin
      unique case (state_q)
        S_IDLE: begin
          unique case (1'b1)
            is_e0: begin
              state_d = S_EXT;
              ext_d   = 1'b1;
            end
            is_f0: begin
              state_d = S_BRK;
              ext_d   = 1'b0;
            end
            is_e1: begin
              push    = 1'b1;
              pdat    = {2'b00, 8'hE1};
              cnt_d   = 3'd7;
              state_d = S_PAUSE;
            end
            is_noise: ;
            default: begin
              push = 1'b1;
              pdat = {2'b00, byte_in};
            end
          endcase
        end
        S_EXT: begin
          if (is_f0) begin
            state_d = S_BRK;
          end else begin
            state_d = S_IDLE;
            ext_d   = 1'b0;
            if (!is_e0 && !is_e1) begin
              push = 1'b1;
              pdat = {2'b01, byte_in};
            end
          end
        end
        S_BRK: begin
          state_d = S_IDLE;
          ext_d   = 1'b0;
          if (!is_e0 && !is_f0 && !is_e1) begin
            push = 1'b1;
            pdat = {1'b1, ext_q, byte_in};
          end
        end
        S_PAUSE: begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge global_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ext_q   <= 1'b0;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      ext_q   <= ext_d;
      cnt_q   <= cnt_d;
    end
  end

  logic [9:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  empty, full;
  logic                  do_pop, do_push, drop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = rd_en & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // A drop in the same cycle as a clear keeps the flag set
  always_comb begin
    ovf_d = ovf_q;
    if (clr_ovf) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  always_ff @(posedge global_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge global_clk) begin
    if (do_push) mem[wr_ptr_q] <= pdat;
  end

  logic [9:0] head;
  assign head      = mem[rd_ptr_q];
  assign evt_avail = ~empty;
  assign evt_count = count_q;
  assign overflow  = ovf_q;
  assign evt_data  = empty ? 16'h0000
                           : {head[9], head[8], 6'b0, head[7:0]};

`ifdef KEY_EVENT_IRQ_EN
  logic irq_q;
  always_ff @(posedge global_clk or negedge rst_n) begin
    if (!rst_n) irq_q <= 1'b0;
    else        irq_q <= evt_avail | ovf_q;
  end
  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_key_event_queue_ctrl.sv
// Randomized + directed bench for key_event_queue_ctrl
// with a queue-based reference model of the event stream.
module tb_key_event_queue_ctrl;

  localparam int DL    = 3;
  localparam int DEPTH = 1 << DL;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    byte_in = 8'h00;
  logic          byte_valid = 1'b0;
  logic          rd_en = 1'b0;
  logic          clr_ovf = 1'b0;
  logic [15:0]   evt_data;
  logic          evt_avail;
  logic [DL:0]   evt_count;
  logic          overflow;
  logic          irq;

  int n_chk = 0;
  int n_fail = 0;

  key_event_queue_ctrl #(.DEPTH_LOG2(DL)) dut (
    .global_clk (clk),
    .rst_n      (rst_n),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .rd_en      (rd_en),
    .clr_ovf    (clr_ovf),
    .evt_data   (evt_data),
    .evt_avail  (evt_avail),
    .evt_count  (evt_count),
    .overflow   (overflow),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h @%0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model: prefix flags plus a plain event queue
  logic [15:0] mq[$];
  bit          m_ext, m_brk, m_ovf, m_irq;
  int          m_skip;

  function automatic bit is_prefix(logic [7:0] b);
    return b == 8'hE0 || b == 8'hF0 || b == 8'hE1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_ext  = 0;
      m_brk  = 0;
      m_ovf  = 0;
      m_irq  = 0;
      m_skip = 0;
    end else begin
      bit          emit, pop, drop;
      logic [15:0] ev;
      int          sz;
      emit = 0;
      ev   = 16'h0;
      sz   = mq.size();
`ifdef KEY_EVENT_IRQ_EN
      m_irq = (sz > 0) || m_ovf;
`endif
      if (byte_valid) begin
        if (m_skip > 0) begin
          m_skip--;
        end else if (m_brk) begin
          if (!is_prefix(byte_in)) begin
            emit = 1;
            ev   = {1'b1, m_ext, 6'b0, byte_in};
          end
          m_brk = 0;
          m_ext = 0;
        end else if (m_ext) begin
          if (byte_in == 8'hF0) m_brk = 1;
          else begin
            if (!is_prefix(byte_in)) begin
              emit = 1;
              ev   = {8'h40, byte_in};
            end
            m_ext = 0;
          end
        end else begin
          case (byte_in)
            8'hE0: m_ext = 1;
            8'hF0: m_brk = 1;
            8'hE1: begin
              emit   = 1;
              ev     = 16'h00E1;
              m_skip = 7;
            end
            8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF: ;
            default: begin
              emit = 1;
              ev   = {8'h00, byte_in};
            end
          endcase
        end
      end
      pop  = rd_en && sz > 0;
      drop = emit && sz == DEPTH && !pop;
      if (pop) void'(mq.pop_front());
      if (emit && !drop) mq.push_back(ev);
      if (clr_ovf) m_ovf = 0;
      if (drop) m_ovf = 1;
    end
  end

  bit cmp_en = 0;
  always @(negedge clk) begin
    if (cmp_en) begin
      logic [15:0] e;
      e = mq.size() > 0 ? mq[0] : 16'h0000;
      check("data", evt_data, e);
      check("avail", evt_avail, mq.size() > 0);
      check("count", evt_count, mq.size());
      check("ovf", overflow, m_ovf);
      check("irq", irq, m_irq);
    end
  end

  task automatic send(logic [7:0] b);
    byte_valid = 1'b1;
    byte_in    = b;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic pop1();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] seq[8];
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    cmp_en = 1;
    check("rst_count", evt_count, 0);
    check("rst_data", evt_data, 16'h0000);
    check("rst_avail", evt_avail, 0);
    check("rst_ovf", overflow, 0);

    send(8'h1C);
    check("make_data", evt_data, 16'h001C);
    check("make_avail", evt_avail, 1);
    check("make_count", evt_count, 1);
    pop1();

    send(8'hE0); send(8'hF0); send(8'h75);
    check("extbrk", evt_data, 16'hC075);
    pop1();
    check("pop_avail", evt_avail, 0);
    check("pop_data", evt_data, 16'h0000);

    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1,
            8'hF0, 8'h14, 8'hF0, 8'h77};
    foreach (seq[i]) send(seq[i]);
    check("pause_cnt", evt_count, 1);
    check("pause_data", evt_data, 16'h00E1);
    pop1();
    send(8'h1C);
    check("post_pause", evt_data, 16'h001C);
    pop1();

    for (int i = 0; i < 9; i++) send(8'h10 + 8'(i));
    check("full_cnt", evt_count, 8);
    check("full_ovf", overflow, 1);
    check("full_head", evt_data, 16'h0010);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    check("clr_ovf", overflow, 0);
    rd_en = 1'b1;
    send(8'h20);
    rd_en = 1'b0;
    check("fullrw_cnt", evt_count, 8);
    check("fullrw_ovf", overflow, 0);
    check("fullrw_head", evt_data, 16'h0011);
    repeat (8) pop1();

    send(8'hE0);
    do_reset();
    send(8'h75);
    check("rst_mid", evt_data, 16'h0075);
    pop1();

    send(8'hAA); send(8'hFA); send(8'hF0); send(8'hF0);
    check("noise_cnt", evt_count, 0);
    send(8'h1C);
    check("noise_idle", evt_data, 16'h001C);
    pop1();

    for (int c = 0; c < 6000; c++) begin
      int r;
      int rd_div;
      rd_div = (c < 3000) ? 7 : 2;
      r = $urandom_range(0, 9);
      byte_valid = ($urandom_range(0, 2) == 0);
      case (r)
        0: byte_in = 8'hE0;
        1: byte_in = 8'hF0;
        2: byte_in = 8'hE1;
        3: byte_in = 8'hAA;
        default: byte_in = 8'($urandom);
      endcase
      rd_en   = ($urandom_range(0, rd_div) == 0);
      clr_ovf = ($urandom_range(0, 20) == 0);
      if ($urandom_range(0, 999) == 0) begin
        byte_valid = 1'b0;
        rd_en      = 1'b0;
        clr_ovf    = 1'b0;
        do_reset();
      end else begin
        @(negedge clk);
      end
    end
    byte_valid = 1'b0;
    rd_en      = 1'b0;
    clr_ovf    = 1'b0;
    @(negedge clk);
    cmp_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
